// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch block.
//   fetch_entry_t  : one queued fetch {pc, instr, misaligned} at default widths
//   Fetch*         : default address width, data width and queue depth
//   is_misaligned  : true when a byte address is not word aligned
package fetch_pkg;

  localparam int unsigned FetchAddrWidth = 16;
  localparam int unsigned FetchDataWidth = 32;
  localparam int unsigned FetchDepth     = 4;

  typedef struct packed {
    logic [FetchAddrWidth-1:0] pc;
    logic [FetchDataWidth-1:0] instr;
    logic                      misaligned;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch block's handshake and memory signals.
//   PC side     : pc_valid, pc, pc_ready
//   Memory side : imem_en, imem_addr, imem_rdata (synchronous, 1-cycle read)
//   Decode side : instr_valid, instr, instr_pc, instr_misaligned, instr_ready
//   Control     : flush
// master = the fetch block, slave = the surrounding pipeline and memory.
interface instr_fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FetchAddrWidth,
  parameter int unsigned DATA_WIDTH = FetchDataWidth
);

  logic                  pc_valid;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_ready;
  logic                  imem_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  flush;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_misaligned;
  logic                  instr_ready;

  modport master (
    input  pc_valid, pc, imem_rdata, flush, instr_ready,
    output pc_ready, imem_en, imem_addr, instr_valid, instr, instr_pc, instr_misaligned
  );

  modport slave (
    output pc_valid, pc, imem_rdata, flush, instr_ready,
    input  pc_ready, imem_en, imem_addr, instr_valid, instr, instr_pc, instr_misaligned
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular instruction queue for the fetch block.
//   clk, rst         : clock, synchronous active-high reset
//   push, push_data  : write an entry at the tail (ignored when full and not popping)
//   pop, pop_data    : consume the head; pop_data always shows the head slot
//   clear            : drop every entry (takes priority over push/pop)
//   full, empty      : occupancy flags
//   count            : number of valid entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = FetchDepth,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned PtrW   = $clog2(DEPTH),
  localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  entry_t          push_data,
  input  logic            pop,
  input  logic            clear,
  output entry_t          pop_data,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full     = (cnt_q == CntW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        // DEPTH is a power of two, so pointers wrap naturally.
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: accepts PCs, issues reads to a synchronous
// instruction memory and queues {pc, instr, misaligned} for decode.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_fetch_if master (PC, memory and decode handshakes, flush)
// A PC accepted in cycle N is held in a one-deep in-flight register; its read
// data returns in N+1 and is pushed then, so it reaches the head in N+2.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FetchAddrWidth,
  parameter int unsigned DATA_WIDTH = FetchDataWidth,
  parameter int unsigned DEPTH      = FetchDepth
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
    logic                  misaligned;
  } entry_t;

  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_mis_q, inflight_mis_d;

  logic                  accept;
  logic [CntW:0]         occupancy;
  logic                  fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [CntW-1:0]       fifo_count;
  logic                  head_valid;
  entry_t                push_entry, head_entry;

  // Reserve a slot for the in-flight read so the queue can never overflow.
  // Depends only on registered state plus rst/flush, never on instr_ready.
  assign occupancy    = {1'b0, fifo_count} + (CntW + 1)'(inflight_q);
  assign bus.pc_ready = !rst && !bus.flush && !fifo_full && (occupancy < (CntW + 1)'(DEPTH));

  assign accept        = bus.pc_valid && bus.pc_ready;
  assign bus.imem_en   = accept;
  assign bus.imem_addr = bus.pc;

  always_comb begin
    inflight_d     = accept;
    inflight_pc_d  = accept ? bus.pc : inflight_pc_q;
    inflight_mis_d = accept ? is_misaligned(bus.pc[1:0]) : inflight_mis_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      inflight_pc_q  <= '0;
      inflight_mis_q <= 1'b0;
    end else begin
      inflight_q     <= inflight_d;
      inflight_pc_q  <= inflight_pc_d;
      inflight_mis_q <= inflight_mis_d;
    end
  end

  // The response landing in a flush cycle belongs to the discarded stream.
  assign fifo_push  = inflight_q && !bus.flush && !rst;
  assign push_entry = '{pc: inflight_pc_q, instr: bus.imem_rdata, misaligned: inflight_mis_q};

  assign head_valid = !rst && !fifo_empty;
  assign fifo_pop   = head_valid && bus.instr_ready;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .clear     (bus.flush),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head fields read as zero whenever nothing valid is presented (incl. reset).
  assign bus.instr_valid      = head_valid;
  assign bus.instr            = head_valid ? head_entry.instr : '0;
  assign bus.instr_pc         = head_valid ? head_entry.pc : '0;
  assign bus.instr_misaligned = head_valid ? head_entry.misaligned : 1'b0;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, sets the PC / instruction-address width.
REQ-002 Parameter DATA_WIDTH, default 32, sets the instruction word width.
REQ-003 Parameter DEPTH, default 4, power of two >= 2, sets the instruction queue entry count.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pc_valid  input  1  the PC source presents a fetch address.
REQ-007 pc  input  ADDR_WIDTH  byte address to fetch.
REQ-008 pc_ready  output  1  the block accepts pc this cycle.
REQ-009 imem_en  output  1  read strobe to the synchronous instruction memory.
REQ-010 imem_addr  output  ADDR_WIDTH  read address; equals pc.
REQ-011 imem_rdata  input  DATA_WIDTH  read data, valid exactly 1 cycle after imem_en.
REQ-012 flush  input  1  redirect; discards all in-flight and queued fetches.
REQ-013 instr_valid  output  1  the queue head is valid.
REQ-014 instr  output  DATA_WIDTH  instruction at the queue head.
REQ-015 instr_pc  output  ADDR_WIDTH  PC of the queue head.
REQ-016 instr_misaligned  output  1  the queue head's pc[1:0] != 0.
REQ-017 instr_ready  input  1  the decode stage consumes the head.

Function
REQ-018 Acceptance: pc_valid && pc_ready in cycle N; imem_en SHALL equal that term combinationally, and imem_addr SHALL equal pc.
REQ-019 pc_ready SHALL be 1 iff !rst && !flush && (count + inflight) < DEPTH; there SHALL be no combinational path from instr_ready to pc_ready.
REQ-020 Accepted PC and misaligned flag SHALL be registered with an inflight bit; in cycle N+1 the entry {pc, imem_rdata, misaligned} SHALL be pushed, so instr_valid rises no earlier than cycle N+2.
REQ-021 Pop occurs when instr_valid && instr_ready; push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-022 Sustained throughput SHALL be 1 instruction per cycle when pc_valid and instr_ready are held high.
REQ-023 Outputs instr, instr_pc and instr_misaligned SHALL hold stable while instr_valid && !instr_ready.
REQ-024 Flush in cycle F: the queue SHALL be empty and inflight 0 from cycle F+1; the response arriving in F SHALL NOT be pushed; no PC SHALL be accepted in F.
REQ-025 A misaligned PC SHALL still be fetched and queued, with instr_misaligned = 1; no other effect.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH (guaranteed by REQ-019).
REQ-027 Full condition: with count + inflight == DEPTH, pc_ready SHALL be 0 and imem_en SHALL be 0 regardless of pc_valid.

Reset
REQ-028 While rst = 1: pc_ready = 0, imem_en = 0, instr_valid = 0, and instr, instr_pc and instr_misaligned SHALL all be 0.
REQ-029 Reset SHALL clear count, pointers and inflight; the in-flight response SHALL be dropped if rst asserts mid-fetch.
REQ-030 pc_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 Package fetch_pkg SHALL hold typedef fetch_entry_t {pc, instr, misaligned} and the default width/depth constants.
REQ-032 The queue SHALL be a sub-module fetch_fifo with push, pop, clear, full, empty and count ports, instanced once.

Verification
REQ-033 Single fetch: pc = 0x0004 accepted in cycle 1, imem_rdata = 0x00500093 in cycle 2 -> instr_valid in cycle 3 with instr = 0x00500093 and instr_pc = 0x0004.
REQ-034 Streaming: PCs 0x0, 0x4, 0x8 ... for 16 cycles with instr_ready = 1 -> 16 instructions, in order, 1 per cycle after 2-cycle latency.
REQ-035 Backpressure: instr_ready = 0 with 6 PCs offered -> exactly 4 accepted, pc_ready = 0 afterwards, head stable; release -> 4 drained in order.
REQ-036 Flush: flush in the cycle a response for 0x0010 arrives with 2 entries queued -> instr_valid = 0 next cycle; next PC 0x0100 is the first output.
REQ-037 Misaligned: pc = 0x0006 -> output with instr_misaligned = 1 and instr_pc = 0x0006.
REQ-038 Reset mid-operation: rst with 3 entries queued and 1 in flight -> all outputs 0 during reset; pc_ready = 1 and no stale instr_valid afterwards.
